// File: rtl/reset_cond_pkg.sv
// Shared types and sizing helper for the push-button reset conditioner.
package reset_cond_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DB_PRESS,
        S_HOLD,
        S_WAIT_REL,
        S_DB_REL
    } rc_state_t;

    function automatic int cnt_width(input int d, input int h);
        int m;
        m = (d > h) ? d : h;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/input_synchronizer.sv
// N-flop synchronizer for an asynchronous single-bit input; reset loads RESET_VAL.
module input_synchronizer #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (reset) chain <= {STAGES{RESET_VAL}};
        else       chain <= {chain[STAGES-2:0], din};
    end

    assign dout = chain[STAGES-1];

endmodule

// File: rtl/button_reset_conditioner.sv
// Debounces the active-low reset button into a fixed-width manual_reset pulse,
// plus a debounced level and press/release strobes.
module button_reset_conditioner
    import reset_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 480000,
    parameter int HOLD_CYCLES     = 4800
) (
    input  logic clk_48mhz,
    input  logic reset,
    input  logic button_n,
    output logic manual_reset,
    output logic button_level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int            CW        = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

    logic          sync_out;
    logic          btn;
    rc_state_t     state;
    logic [CW-1:0] cnt;

    // Sync chain resets to released so a reset never looks like a press.
    input_synchronizer #(
        .STAGES   (SYNC_STAGES),
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk  (clk_48mhz),
        .reset(reset),
        .din  (button_n),
        .dout (sync_out)
    );

    assign btn = ~sync_out;

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            manual_reset  <= 1'b0;
            button_level  <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (btn) begin
                        state <= S_DB_PRESS;
                        cnt   <= '0;
                    end
                end
                S_DB_PRESS: begin
                    if (!btn) begin
                        state <= S_IDLE;
                    end else if (cnt == DB_LAST) begin
                        state        <= S_HOLD;
                        cnt          <= '0;
                        press_pulse  <= 1'b1;
                        manual_reset <= 1'b1;
                        button_level <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                // Button activity is ignored here so the pulse width is fixed.
                S_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state        <= S_WAIT_REL;
                        cnt          <= '0;
                        manual_reset <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_WAIT_REL: begin
                    if (!btn) begin
                        state <= S_DB_REL;
                        cnt   <= '0;
                    end
                end
                S_DB_REL: begin
                    if (btn) begin
                        state <= S_WAIT_REL;
                    end else if (cnt == DB_LAST) begin
                        state         <= S_IDLE;
                        cnt           <= '0;
                        release_pulse <= 1'b1;
                        button_level  <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_reset_conditioner.sv
// Scoreboard bench: stimulus queues expected events, a negedge monitor pops and compares.
module tb_button_reset_conditioner;
    import reset_cond_pkg::*;

    localparam int SS = 2;
    localparam int DB = 8;
    localparam int HC = 4;
    localparam int LAT = SS + DB;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    logic clk_48mhz = 1'b0;
    logic reset     = 1'b1;
    logic button_n  = 1'b1;
    logic manual_reset, button_level, press_pulse, release_pulse;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t_edge = 0;
    bit mon_en = 1'b0;

    ev_t q_press[$];
    ev_t q_rel[$];
    ev_t q_lvl[$];
    ev_t q_mr[$];

    button_reset_conditioner #(
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES    (HC)
    ) dut (
        .clk_48mhz    (clk_48mhz),
        .reset        (reset),
        .button_n     (button_n),
        .manual_reset (manual_reset),
        .button_level (button_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    always #5 clk_48mhz = ~clk_48mhz;
    always @(posedge clk_48mhz) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every observed event must match the head of its queue.
    logic prev_lvl = 1'b0;
    logic prev_mr  = 1'b0;
    int   mr_start = 0;
    always @(negedge clk_48mhz) begin
        ev_t e;
        if (mon_en) begin
            if (press_pulse === 1'b1) begin
                if (q_press.size() == 0) chk("unexpected_press", cyc, -1);
                else begin e = q_press.pop_front(); chk("press_cycle", cyc, e.cyc); end
            end
            if (release_pulse === 1'b1) begin
                if (q_rel.size() == 0) chk("unexpected_release", cyc, -1);
                else begin e = q_rel.pop_front(); chk("release_cycle", cyc, e.cyc); end
            end
            if (button_level !== prev_lvl) begin
                if (q_lvl.size() == 0) chk("unexpected_level", int'(button_level), -1);
                else begin
                    e = q_lvl.pop_front();
                    chk("level_cycle", cyc, e.cyc);
                    chk("level_value", int'(button_level), e.val);
                end
            end
            if (manual_reset === 1'b1 && prev_mr === 1'b0) mr_start = cyc;
            if (manual_reset === 1'b0 && prev_mr === 1'b1) begin
                if (q_mr.size() == 0) chk("unexpected_mr", mr_start, -1);
                else begin
                    e = q_mr.pop_front();
                    chk("mr_start", mr_start, e.cyc);
                    chk("mr_width", cyc - mr_start, e.val);
                end
            end
            prev_lvl = button_level;
            prev_mr  = manual_reset;
        end
    end

    task automatic drive(input logic v);
        @(negedge clk_48mhz);
        button_n = v;
        t_edge   = cyc + 1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_48mhz);
    endtask

    task automatic exp_press(input int t, input int width);
        q_press.push_back('{t + LAT, 0});
        q_lvl.push_back('{t + LAT, 1});
        q_mr.push_back('{t + LAT, width});
    endtask

    task automatic exp_release(input int c);
        q_rel.push_back('{c, 0});
        q_lvl.push_back('{c, 0});
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tp;
        wait_cyc(3);
        chk("rst_manual_reset", int'(manual_reset), 0);
        chk("rst_button_level", int'(button_level), 0);
        chk("rst_press_pulse", int'(press_pulse), 0);
        chk("rst_release_pulse", int'(release_pulse), 0);
        chk("rst_state", int'(dut.state), int'(S_IDLE));
        reset  = 1'b0;
        mon_en = 1'b1;
        wait_cyc(3);

        // 1: clean press, 40 cycles
        drive(1'b0); exp_press(t_edge, HC);
        wait_cyc(39);
        drive(1'b1); exp_release(t_edge + LAT);
        wait_cyc(20);

        // 2: 5-cycle bounce rejected
        drive(1'b0);
        wait_cyc(4);
        drive(1'b1);
        wait_cyc(20);
        chk("bounce_state", int'(dut.state), int'(S_IDLE));
        chk("bounce_mr", int'(manual_reset), 0);

        // 3: long hold, single pulse
        drive(1'b0); exp_press(t_edge, HC);
        wait_cyc(99);
        drive(1'b1); exp_release(t_edge + LAT);
        wait_cyc(20);

        // 4: 3-cycle release glitch while waiting for release
        drive(1'b0); exp_press(t_edge, HC);
        wait_cyc(29);
        drive(1'b1);
        wait_cyc(2);
        drive(1'b0);
        wait_cyc(29);
        drive(1'b1); exp_release(t_edge + LAT);
        wait_cyc(20);

        // 5: reset during second cycle of manual_reset
        drive(1'b0); tp = t_edge;
        q_press.push_back('{tp + LAT, 0});
        q_lvl.push_back('{tp + LAT, 1});
        q_mr.push_back('{tp + LAT, 2});
        q_lvl.push_back('{tp + LAT + 2, 0});
        wait_cyc(12);
        reset = 1'b1;
        wait_cyc(1);
        reset = 1'b0;
        exp_press(tp + 13, HC);
        wait_cyc(30);
        drive(1'b1); exp_release(t_edge + LAT);
        wait_cyc(20);

        // 6: back-to-back press/release/press, 12 cycles each
        drive(1'b0); tp = t_edge; exp_press(tp, HC);
        wait_cyc(11);
        drive(1'b1);
        exp_release(tp + 23);
        wait_cyc(11);
        drive(1'b0); exp_press(t_edge, HC);
        wait_cyc(29);
        drive(1'b1); exp_release(t_edge + LAT);
        wait_cyc(20);

        chk("left_press", q_press.size(), 0);
        chk("left_release", q_rel.size(), 0);
        chk("left_level", q_lvl.size(), 0);
        chk("left_mr", q_mr.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
